// File: rtl/clocks_pkg.sv
// Shared sizes, compare-op encodings and the compare helper for the clocks_module time base.
package clocks_pkg;

    localparam int NUM_CLK = 8;
    localparam int CLK_W   = 4;
    localparam int NUM_DIV = 4;
    localparam int DIV_W   = 10;
    localparam int LONG_W  = 12;

    typedef enum logic {
        OP_EQ = 1'b0,
        OP_LT = 1'b1
    } op_e;

    typedef logic [CLK_W-1:0]  clk_cnt_t;
    typedef logic [LONG_W-1:0] long_t;

    // Short-mode operands are zero-extended, so one 12-bit compare serves both widths.
    function automatic logic cmp_result(input logic op, input long_t operand, input long_t imm);
        return (op_e'(op) == OP_LT) ? (operand < imm) : (operand == imm);
    endfunction

endpackage

// File: rtl/clk_divider.sv
// One 10-bit divider stage: counts advances and ticks once the count reaches the limit.
module clk_divider
    import clocks_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [DIV_W-1:0] limit,
    output logic [DIV_W-1:0] count,
    output logic             tick
);

    // >= rather than == lets a limit lowered below the count recover on the next advance.
    assign tick = advance && (count >= limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/clocks_module.sv
// Time base: four cascaded dividers feed eight 4-bit event counters with a registered compare.
// Optional feature: define CLOCKS_JOIN_EN to let cfg_clk_joins chain adjacent counters.
module clocks_module
    import clocks_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op,
    input  logic [CLK_W-1:0]        imm_lo,
    input  logic [LONG_W-CLK_W-1:0] imm_hi,
    input  logic [1:0]              addr,
    input  logic                    long,
    input  logic                    en_clk_reset,
    input  logic [NUM_CLK-1:0]      clk_reset,
    input  logic [NUM_CLK-1:0]      cfg_clk_joins,
    input  logic [NUM_DIV*DIV_W-1:0] cfg_div_limits,
    output logic                    out_val
);

    logic                        tick_0, tick_1, tick_2, tick_3;
    logic [NUM_DIV-1:0]          div_tick;
    logic [DIV_W-1:0]            div_cnt_unused [NUM_DIV];

    logic [NUM_CLK-1:0]          join_src;
    logic                        unused_join;

    clk_cnt_t [NUM_CLK-1:0]      cnt;
    clk_cnt_t [NUM_CLK-1:0]      cnt_next;
    logic                        inc;
    logic                        clr;
    logic                        carry;

    logic [2:0]                  base;
    long_t                       operand;
    long_t                       imm;

    // Divider cascade: each stage advances only on the previous stage's tick.
    clk_divider u_div0 (
        .clk     (clk),
        .reset   (reset),
        .advance (1'b1),
        .limit   (cfg_div_limits[0*DIV_W +: DIV_W]),
        .count   (div_cnt_unused[0]),
        .tick    (tick_0)
    );

    clk_divider u_div1 (
        .clk     (clk),
        .reset   (reset),
        .advance (tick_0),
        .limit   (cfg_div_limits[1*DIV_W +: DIV_W]),
        .count   (div_cnt_unused[1]),
        .tick    (tick_1)
    );

    clk_divider u_div2 (
        .clk     (clk),
        .reset   (reset),
        .advance (tick_1),
        .limit   (cfg_div_limits[2*DIV_W +: DIV_W]),
        .count   (div_cnt_unused[2]),
        .tick    (tick_2)
    );

    clk_divider u_div3 (
        .clk     (clk),
        .reset   (reset),
        .advance (tick_2),
        .limit   (cfg_div_limits[3*DIV_W +: DIV_W]),
        .count   (div_cnt_unused[3]),
        .tick    (tick_3)
    );

    assign div_tick = {tick_3, tick_2, tick_1, tick_0};

    // join_src[i] set means counter i takes its increment from counter i-1's carry.
`ifdef CLOCKS_JOIN_EN
    assign join_src    = {cfg_clk_joins[NUM_CLK-2:0], 1'b0};
    assign unused_join = cfg_clk_joins[NUM_CLK-1];
`else
    assign join_src    = '0;
    assign unused_join = ^cfg_clk_joins;
`endif

    // Carry ripples low to high in one pass; a cleared counter never passes a carry on.
    always_comb begin
        cnt_next = cnt;
        inc      = 1'b0;
        clr      = 1'b0;
        carry    = 1'b0;
        for (int i = 0; i < NUM_CLK; i++) begin
            inc = join_src[i] ? carry : div_tick[i/2];
            clr = en_clk_reset && clk_reset[i];
            if (clr) begin
                cnt_next[i] = '0;
            end else if (inc) begin
                cnt_next[i] = cnt[i] + 1'b1;
            end
            carry = inc && !clr && (cnt[i] == '1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Window base is an even counter index; the +2 wraps modulo eight in 3 bits.
    always_comb begin
        base    = {addr, 1'b0};
        operand = '0;
        imm     = '0;
        if (long) begin
            operand = {cnt[base + 3'd2], cnt[base + 3'd1], cnt[base]};
            imm     = {imm_hi, imm_lo};
        end else begin
            operand = {{(LONG_W-CLK_W){1'b0}}, cnt[{addr, imm_hi[0]}]};
            imm     = {{(LONG_W-CLK_W){1'b0}}, imm_lo};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val <= 1'b0;
        end else begin
            out_val <= cmp_result(op, operand, imm);
        end
    end

endmodule

// File: tb/tb_clocks_module.sv
// Self-checking bench for clocks_module: constant vector table, hand-timed sequences, model scoreboard.
`timescale 1ns/1ps
module tb_clocks_module;

    logic        clk = 1'b0;
    logic        reset;
    logic        op;
    logic [3:0]  imm_lo;
    logic [7:0]  imm_hi;
    logic [1:0]  addr;
    logic        lng;
    logic        en_clk_reset;
    logic [7:0]  clk_reset;
    logic [7:0]  cfg_clk_joins;
    logic [39:0] cfg_div_limits;
    logic        out_val;

    clocks_module dut (
        .clk            (clk),
        .reset          (reset),
        .op             (op),
        .imm_lo         (imm_lo),
        .imm_hi         (imm_hi),
        .addr           (addr),
        .long           (lng),
        .en_clk_reset   (en_clk_reset),
        .clk_reset      (clk_reset),
        .cfg_clk_joins  (cfg_clk_joins),
        .cfg_div_limits (cfg_div_limits),
        .out_val        (out_val)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int edge_n = 0;
    bit exp_q[$];
    int m_div[4];
    int m_cnt[8];

    typedef struct {
        bit         op;
        bit         lng;
        logic [1:0] addr;
        logic [7:0] hi;
        logic [3:0] lo;
        bit         exp;
    } vec_t;

    vec_t tbl[10];

    function automatic bit model_out();
        int a, opnd, immv;
        a = int'(addr);
        if (!lng) begin
            opnd = m_cnt[2*a + int'(imm_hi[0])];
            immv = int'(imm_lo);
        end else begin
            opnd = m_cnt[(2*a+2) % 8]*256 + m_cnt[2*a+1]*16 + m_cnt[2*a];
            immv = int'(imm_hi)*16 + int'(imm_lo);
        end
        return op ? (opnd < immv) : (opnd == immv);
    endfunction

    task automatic model_edge();
        bit t[4];
        bit adv, src, cy;
        int lim;
        adv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lim = int'(cfg_div_limits[k*10 +: 10]);
            t[k] = adv && (m_div[k] >= lim);
            if (t[k]) m_div[k] = 0;
            else if (adv) m_div[k] = m_div[k] + 1;
            adv = t[k];
        end
        cy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            src = t[i/2];
`ifdef CLOCKS_JOIN_EN
            if (i > 0) begin
                if (cfg_clk_joins[i-1]) src = cy;
            end
`endif
            if (en_clk_reset && clk_reset[i]) begin
                m_cnt[i] = 0;
                cy = 1'b0;
            end else if (src) begin
                cy = (m_cnt[i] == 15);
                m_cnt[i] = (m_cnt[i] + 1) % 16;
            end else begin
                cy = 1'b0;
            end
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: out_val=%b expected %b at edge %0d", name, act, exp, edge_n);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one clock: queue the expectation, advance the model, then compare after the edge.
    task automatic step(input bit use_exp, input bit exp_in, input string name);
        bit e;
        e = use_exp ? exp_in : model_out();
        exp_q.push_back(e);
        model_edge();
        @(posedge clk);
        #1;
        edge_n++;
        check_bit(name, out_val, exp_q.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) m_div[k] = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_out", out_val, 1'b0);
        reset  = 1'b1;
        edge_n = 0;
    endtask

    task automatic first_high(input int bound, input int want, input string name);
        int got;
        got = -1;
        while (edge_n < bound) begin
            step(1'b0, 1'b0, name);
            if (out_val === 1'b1) begin
                got = edge_n;
                break;
            end
        end
        check_int(name, got, want);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        reset          = 1'b0;
        op             = 1'b0;
        imm_lo         = '0;
        imm_hi         = '0;
        addr           = '0;
        lng            = 1'b0;
        en_clk_reset   = 1'b0;
        clk_reset      = '0;
        cfg_clk_joins  = '0;
        cfg_div_limits = '1;

        // All counters stay zero for ~1000 edges with every limit at 1023.
        tbl[0] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h5, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'h1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 2'd3, 8'h01, 4'h0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 2'd2, 8'h00, 4'h0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 2'd2, 8'h10, 4'h0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 2'd0, 8'h00, 4'h0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 2'd3, 8'h80, 4'h0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 2'd1, 8'hFE, 4'h0, 1'b1};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            op     = tbl[i].op;
            lng    = tbl[i].lng;
            addr   = tbl[i].addr;
            imm_hi = tbl[i].hi;
            imm_lo = tbl[i].lo;
            step(1'b1, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Less-than zero can never be true.
        cfg_div_limits = {10'd10, 10'd2, 10'd4, 10'd0};
        op = 1'b1; lng = 1'b0; addr = 2'd0; imm_hi = 8'h00; imm_lo = 4'h0;
        do_reset();
        repeat (4096) step(1'b1, 1'b0, "idle_lt0");

        // Cadence: C0 every edge, C2 every 5, C4 every 15, C6 every 165.
        op = 1'b0; imm_lo = 4'd3;
        do_reset();
        first_high(40, 4, "c0_first_eq3");
        hits = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b0, "c0_run");
            if (out_val === 1'b1) hits++;
        end
        check_int("c0_eq3_per_64", hits, 4);

        imm_lo = 4'd1; addr = 2'd1;
        do_reset();
        first_high(40, 6, "c2_first");
        addr = 2'd2;
        do_reset();
        first_high(60, 16, "c4_first");
        addr = 2'd3;
        do_reset();
        first_high(400, 166, "c6_first");

        // Window {C4,C3,C2} == 12'h011.
        cfg_clk_joins = 8'b0001_1100;
        lng = 1'b1; addr = 2'd1; op = 1'b0; imm_hi = 8'h01; imm_lo = 4'h1;
        do_reset();
`ifdef CLOCKS_JOIN_EN
        first_high(200, 86, "join_window_17");
`else
        first_high(200, 6, "nojoin_window_11");
`endif
        repeat (200) step(1'b0, 1'b0, "join_run");

        // Clear while C0=15 with a tick pending; C1 must see no carry.
        cfg_div_limits = {10'd1023, 10'd1023, 10'd1023, 10'd0};
        cfg_clk_joins  = 8'h01;
        lng = 1'b1; addr = 2'd0; op = 1'b0; imm_hi = 8'h00; imm_lo = 4'h0;
        do_reset();
        repeat (15) step(1'b0, 1'b0, "pre_clear");
        en_clk_reset = 1'b1; clk_reset = 8'hFF;
        step(1'b0, 1'b0, "clear_edge");
        en_clk_reset = 1'b0; clk_reset = 8'h00;
        step(1'b1, 1'b1, "clear_window_zero");
        repeat (40) step(1'b0, 1'b0, "post_clear");

        // Long less-than FFF fails only when the window reads FFF.
        cfg_div_limits = '0;
        cfg_clk_joins  = 8'h00;
        op = 1'b1; lng = 1'b1; addr = 2'd0; imm_hi = 8'hFF; imm_lo = 4'hF;
        do_reset();
        hits = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b0, "long_lt");
            if (out_val === 1'b0) hits++;
        end
        check_int("long_lt_zeros", hits, 4);
        step(1'b1, 1'b1, "long_lt_after");

        // Asynchronous reset between edges.
        #3;
        reset = 1'b0;
        #1;
        check_bit("async_reset", out_val, 1'b0);
        do_reset();

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) begin
                for (int k = 0; k < 4; k++) cfg_div_limits[k*10 +: 10] = 10'($urandom_range(0, 7));
                cfg_clk_joins = 8'($urandom);
            end
            op           = 1'($urandom);
            lng          = 1'($urandom);
            addr         = 2'($urandom);
            imm_lo       = 4'($urandom);
            imm_hi       = 8'($urandom);
            en_clk_reset = ($urandom_range(0, 7) == 0);
            clk_reset    = 8'($urandom);
            step(1'b0, 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clocks_module.md
# clocks_module

Programmable time-base block: a cascaded chain of four 10-bit clock dividers drives eight 4-bit event counters. Adjacent counters can be joined into wider counters. One counter, or a 12-bit window of three counters, is compared against an immediate, producing a single-bit result. It sits beside the instruction decoder, which supplies the op, immediate and address fields and consumes `out_val` as a condition flag.

## Interface
- No parameters; all sizes come from `clocks_pkg`.
- `clk` in 1 — single clock; all state is on the rising edge.
- `reset` in 1 — asynchronous, active-low (asserted at 0); clears all state.
- `op` in 1 — compare mode: 0 = equal, 1 = unsigned less-than.
- `imm_lo` in 4 — immediate, bits [3:0].
- `imm_hi` in 8 — immediate, bits [11:4]; bit 0 also supplies the short-mode index LSB.
- `addr` in 2 — counter or window select.
- `long` in 1 — 0 = 4-bit compare; 1 = 12-bit compare.
- `en_clk_reset` in 1 — qualifies `clk_reset`.
- `clk_reset` in 8 — per-counter synchronous clear mask.
- `cfg_clk_joins` in 8 — bit i set chains counter i+1 to the carry of counter i; bit 7 is reserved and ignored.
- `cfg_div_limits` in 40 — divider k limit L_k = `[10k+9:10k]`.
- `out_val` out 1 — registered compare result.

## Operation
- **Dividers D0..D3**
  - D0 advances every cycle. Dk (k>0) advances only when D(k-1) ticks.
  - `tick_k` = advance_k && cnt_k >= L_k. On a tick, cnt_k <= 0; otherwise, on advance, cnt_k <= cnt_k+1.
  - L=0 ticks on every advance. The `>=` rule handles a limit lowered below the current count: the divider ticks on its next advance.
- **Counters C0..C7** (4-bit, wrapping)
  - Default source: `tick_(i/2)`.
  - With join bit i set, C(i+1) increments instead on `carry_i` = inc_i && C_i==15.
  - Carries ripple combinationally, so a join chain of any length updates in the same cycle.
- **Clear:** when `en_clk_reset`=1, every C_i with `clk_reset[i]`=1 loads 0. Clear has priority over increment and suppresses that counter's carry. Dividers are not affected.
- **Operand selection**
  - `long`=0: operand = C_{`addr`,`imm_hi[0]`}; immediate = `imm_lo`.
  - `long`=1: operand = {C_(2a+2 mod 8), C_(2a+1), C_(2a)} with a=`addr`; immediate = {`imm_hi`,`imm_lo`}.
- **Compare:** `out_val` <= `op` ? (operand < imm) : (operand == imm), unsigned, at the selected width.

## Timing
- Reset values: all divider counts, all counters and `out_val` = 0. After release, D0 advances on the first edge.
- Counter increments, clears and divider updates all take effect on the same edge that evaluates the tick.
- `out_val` has one-cycle latency. It samples pre-edge counter values and the current op/imm/addr/long.
- A simultaneous clear and carry-in on the same counter resolves to the clear.
- The 4-bit counters and the 12-bit window wrap silently; no overflow flag exists.
- Reset asserted mid-count zeroes state immediately (asynchronously).

## Configuration
- `CLOCKS_JOIN_EN`
  - Defined: counter joining via `cfg_clk_joins` is active as described above.
  - Undefined: `cfg_clk_joins` is ignored, and every C_i always counts `tick_(i/2)`.

## Structure
- `clocks_pkg` holds:
  - constants NUM_CLK=8, CLK_W=4, NUM_DIV=4, DIV_W=10, LONG_W=12;
  - the op encodings OP_EQ=0 and OP_LT=1.
- Sub-module `clk_divider`: one 10-bit divider (advance, limit, count, tick), instantiated four times in a cascade.

## Test plan
- **Reset and idle:** Hold `reset`=0 for 2 cycles, then release. Set `op`=1, `long`=0, `addr`=0, `imm_lo`=0 → `out_val` stays 0 for 4096 cycles.
- **Divider cadence:** limits {10,2,4,0} (D3..D0) → C0 increments every cycle, C2 every 5, C4 every 15, C6 every 165.
- **Equal match:** Limits as above. Set `op`=0, `long`=0, `addr`=0, `imm_hi[0]`=0, `imm_lo`=3 → `out_val` is high for one cycle in every 16; it first rises on the edge after C0 reads 3.
- **Join chain:** Set `cfg_clk_joins`=8'b00011100 (C2→C3→C4→C5). C3 increments only when C2 wraps 15→0. With `long`=1 and `addr`=1, the window {C4,C3,C2} counts by one every 5 cycles.
- **Clear priority:** Pulse `en_clk_reset`=1 with `clk_reset`=8'hFF while C0=15 and a tick is pending → all counters read 0 next cycle, and C1 receives no carry.
- **Long less-than:** Set `op`=1, `long`=1, `imm_hi`=8'hFF, `imm_lo`=4'hF → `out_val`=1 unless the window equals 12'hFFF. Build without `CLOCKS_JOIN_EN` → the join bits have no effect.
